gfx_mem_arbiter: RTL
====================

Name: gfx_mem_arbiter

Overview:
- Shares the single DDR request path (address FIFO "af", write-data FIFO "wdf") between two graphics engines: requester 0 (line engine) and requester 1 (circle engine).
- Grants one requester a whole write transaction: 1 af entry plus 2 wdf beats.
- Arbitration is round-robin.
- The non-granted requester is stalled by forcing its af_full/wdf_full high.
- Sits between the engines and the memory-controller FIFOs.

Parameters:
- ADDR_W, 31, af address width
- DATA_W, 128, wdf data width
- MASK_W, 16, wdf byte-mask width (DATA_W/8)
- BEATS, 2, wdf beats per transaction

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rN_af_addr_din  in  ADDR_W  requester N address (N=0,1)
- rN_af_wr_en  in  1  requester N af write
- rN_wdf_din  in  DATA_W  requester N write data
- rN_wdf_mask_din  in  MASK_W  requester N mask (1 = byte not written)
- rN_wdf_wr_en  in  1  requester N wdf write
- rN_af_full  out  1  stall to requester N af
- rN_wdf_full  out  1  stall to requester N wdf
- af_addr_din  out  ADDR_W  to controller
- af_wr_en  out  1  to controller
- wdf_din  out  DATA_W  to controller
- wdf_mask_din  out  MASK_W  to controller
- wdf_wr_en  out  1  to controller
- af_full  in  1  from controller
- wdf_full  in  1  from controller
- grant_cnt0  out  32  transactions completed by requester 0 (see Optional Feature)
- grant_cnt1  out  32  transactions completed by requester 1

Behaviour:
- Request: reqN = rN_af_wr_en | rN_wdf_wr_en. A requester holds its wr_en while its full is high.
- States: IDLE, GRANT0, GRANT1. Registered last-grant pointer lg; reset lg=1, so requester 0 wins the first tie.
- Reset (asynchronous, any time including mid-transaction):
  - State to IDLE; af_cnt=0, wdf_cnt=0.
  - Downstream af_wr_en/wdf_wr_en=0.
  - All rN_*_full=1.
  - Counters=0.
  - A partial transaction is abandoned, not completed.
- IDLE:
  - All rN_*_full=1; downstream wr_en=0; data/address outputs=0.
  - One request goes to GRANT of that requester next cycle.
  - Both requesting: grant !lg.
  - Grant latency 1 cycle.
- GRANTn, combinational mux:
  - Downstream af/wdf signals = requester n's signals.
  - rn_af_full = af_full | (af_cnt==1).
  - rn_wdf_full = wdf_full | (wdf_cnt==BEATS).
  - Other requester's fulls = 1.
  - Downstream af_wr_en = rn_af_wr_en & !rn_af_full; wdf_wr_en likewise. Quota overruns are never forwarded.
- Accounting: an af write is accepted when af_wr_en & !af_full (af_cnt 0→1). A wdf beat is accepted when wdf_wr_en & !wdf_full (wdf_cnt +1). af and wdf may be accepted in the same cycle, in either order.
- Completion: the cycle in which the accepted totals reach af=1 and wdf=BEATS (counting that cycle's accepts). Next cycle:
  - Counters clear; lg=n.
  - If the other requester is requesting, go to GRANT of it (no IDLE bubble).
  - Else if n is still requesting, stay in GRANTn (new transaction).
  - Else go to IDLE.
- Downstream full asserted mid-transaction: grant held indefinitely; no timeout.
- grant_cnt wraps at 2^32.

Optional Feature:
- Macro: GFX_ARB_PERF_CNT_EN.
- Defined: grant_cntN increments on each completion by requester N.
- Undefined: no counter registers; grant_cnt0/1 tied to 0.
- Arbitration is identical in both builds.

Test Plan:
- Only r1 issues addr 0x0010_0040 plus 2 beats (mask 0x0FFF) → r1 fulls drop 1 cycle after request; downstream sees exactly 1 af and 2 wdf writes with identical address/data/mask; back to IDLE; grant_cnt1=1.
- r0 and r1 both request from reset → r0 served first, r1 served immediately after completion with no IDLE cycle; r0 fulls stay 1 throughout r1's transaction.
- r0 requests continuously with r1 idle, then r1 requests mid-stream → grants alternate r0, r1, r0 (round-robin); grant_cnt0=2, grant_cnt1=1.
- r1 asserts wdf_wr_en for 3 beats → the 3rd beat sees r1_wdf_full=1 and is not forwarded; the 3rd beat is forwarded as the first beat of the next r1 transaction.
- af_full=1 for 5 cycles during GRANT0 → no downstream af write; grant held; transaction completes once af_full=0.
- rst pulsed after 1 wdf beat of a GRANT1 transaction → immediately all fulls=1, wr_en=0, state IDLE, counters 0; the next request is granted normally.

Source files
------------

// File: rtl/gfx_mem_arbiter_if.sv
// Request-path bundle shared by the graphics engines and the DDR controller FIFOs:
// one address FIFO (af) write port and one write-data FIFO (wdf) write port.
interface gfx_mem_arbiter_if #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
);
    logic [ADDR_W-1:0] af_addr_din;
    logic              af_wr_en;
    logic [DATA_W-1:0] wdf_din;
    logic [MASK_W-1:0] wdf_mask_din;
    logic              wdf_wr_en;
    logic              af_full;
    logic              wdf_full;

    modport master (
        output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
        input  af_full, wdf_full
    );

    modport slave (
        input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
        output af_full, wdf_full
    );
endinterface

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter granting whole write transactions (1 af entry + BEATS wdf beats)
// to two engines. Optional completion counters are enabled by GFX_ARB_PERF_CNT_EN.
module gfx_mem_arbiter #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16,
    parameter int BEATS  = 2
) (
    input  logic                clk,
    input  logic                rst,
    gfx_mem_arbiter_if.slave    r0,
    gfx_mem_arbiter_if.slave    r1,
    gfx_mem_arbiter_if.master   mem,
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state, state_next;
    logic              lg, lg_next;
    logic              af_cnt, af_cnt_next;
    logic [CNT_W-1:0]  wdf_cnt, wdf_cnt_next;

    logic              req0, req1;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_af_wr_en;
    logic [DATA_W-1:0] sel_data;
    logic [MASK_W-1:0] sel_mask;
    logic              sel_wdf_wr_en;
    logic              gated_af_full, gated_wdf_full;
    logic              af_acc, wdf_acc;
    logic [CNT_W-1:0]  wdf_total;
    logic              done;
    logic              own_pending;
    logic              other_req;

    assign req0 = r0.af_wr_en | r0.wdf_wr_en;
    assign req1 = r1.af_wr_en | r1.wdf_wr_en;

    // Datapath mux: the granted engine sees the controller's full flags plus its quota limit.
    always_comb begin
        sel_addr      = '0;
        sel_af_wr_en  = 1'b0;
        sel_data      = '0;
        sel_mask      = '0;
        sel_wdf_wr_en = 1'b0;
        case (state)
            GRANT0: begin
                sel_addr      = r0.af_addr_din;
                sel_af_wr_en  = r0.af_wr_en;
                sel_data      = r0.wdf_din;
                sel_mask      = r0.wdf_mask_din;
                sel_wdf_wr_en = r0.wdf_wr_en;
            end
            GRANT1: begin
                sel_addr      = r1.af_addr_din;
                sel_af_wr_en  = r1.af_wr_en;
                sel_data      = r1.wdf_din;
                sel_mask      = r1.wdf_mask_din;
                sel_wdf_wr_en = r1.wdf_wr_en;
            end
            default: ;
        endcase

        gated_af_full  = mem.af_full | af_cnt;
        gated_wdf_full = mem.wdf_full | (wdf_cnt == BEATS_C);
        af_acc         = sel_af_wr_en & ~gated_af_full;
        wdf_acc        = sel_wdf_wr_en & ~gated_wdf_full;

        mem.af_addr_din  = sel_addr;
        mem.af_wr_en     = af_acc;
        mem.wdf_din      = sel_data;
        mem.wdf_mask_din = sel_mask;
        mem.wdf_wr_en    = wdf_acc;

        r0.af_full  = (state == GRANT0) ? gated_af_full  : 1'b1;
        r0.wdf_full = (state == GRANT0) ? gated_wdf_full : 1'b1;
        r1.af_full  = (state == GRANT1) ? gated_af_full  : 1'b1;
        r1.wdf_full = (state == GRANT1) ? gated_wdf_full : 1'b1;
    end

    // Completion counts this cycle's accepts; an accepted write is consumed, so only
    // a write still being held back counts as the owner wanting another transaction.
    always_comb begin
        state_next   = state;
        lg_next      = lg;
        wdf_total    = wdf_cnt + CNT_W'(wdf_acc);
        af_cnt_next  = af_cnt | af_acc;
        wdf_cnt_next = wdf_total;
        done         = (state != IDLE) && (af_cnt | af_acc) && (wdf_total == BEATS_C);
        own_pending  = (sel_af_wr_en & ~af_acc) | (sel_wdf_wr_en & ~wdf_acc);
        other_req    = (state == GRANT0) ? req1 : req0;

        case (state)
            IDLE: begin
                if (req0 && (!req1 || lg))
                    state_next = GRANT0;
                else if (req1)
                    state_next = GRANT1;
            end
            default: begin
                if (done) begin
                    af_cnt_next  = 1'b0;
                    wdf_cnt_next = '0;
                    lg_next      = (state == GRANT1);
                    if (other_req)
                        state_next = (state == GRANT0) ? GRANT1 : GRANT0;
                    else if (!own_pending)
                        state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lg      <= 1'b1;
            af_cnt  <= 1'b0;
            wdf_cnt <= '0;
        end else begin
            state   <= state_next;
            lg      <= lg_next;
            af_cnt  <= af_cnt_next;
            wdf_cnt <= wdf_cnt_next;
        end
    end

`ifdef GFX_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (done) begin
            if (state == GRANT1)
                grant_cnt1 <= grant_cnt1 + 32'd1;
            else
                grant_cnt0 <= grant_cnt0 + 32'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
